// File: rtl/dm_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and memory.
// Request fields are held stable by the master until the one-cycle ack.
interface dm_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: alignment, lane steering,
// bus handshake with timeout, and load extraction.
module dm_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_mem_dm_r,
    input  logic                     ex_mem_dm_w,
    input  logic [31:0]              ex_mem_alu_result,
    input  logic [31:0]              ex_mem_dm_w_data,
    input  logic [1:0]               ex_mem_dm_size,
    input  logic                     ex_mem_dm_sext,
    dm_access_ctrl_if.master         mem,
    output logic                     dm_stall,
    output logic [31:0]              dm_r_data,
    output logic                     dm_r_valid,
    output logic                     dm_fault,
    output logic                     dm_timeout
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state;

    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt;

    logic        r_mem_req;
    logic        w_mem_req;
    logic        r_mem_we;
    logic        w_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] w_mem_addr;
    logic [3:0]  r_mem_be;
    logic [3:0]  w_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] w_mem_wdata;

    logic [31:0] r_r_data;
    logic [31:0] w_r_data;
    logic        r_r_valid;
    logic        w_r_valid;
    logic        r_fault;
    logic        w_fault;
    logic        r_timeout;
    logic        w_timeout;

    // Request attributes captured at acceptance for the load return path
    logic        r_load;
    logic        w_load;
    logic [1:0]  r_size;
    logic [1:0]  w_size;
    logic [1:0]  r_off;
    logic [1:0]  w_off;
    logic        r_sext;
    logic        w_sext;

    logic        w_any_req;
    logic        w_conflict;
    logic        w_misal;
    logic        w_is_byte;
    logic        w_is_half;
    logic [3:0]  w_req_be;
    logic [31:0] w_req_wdata;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_ld_data;

    assign w_any_req  = ex_mem_dm_r | ex_mem_dm_w;
    assign w_conflict = ex_mem_dm_r & ex_mem_dm_w;
    assign w_is_byte  = (ex_mem_dm_size == 2'b00);
    assign w_is_half  = (ex_mem_dm_size == 2'b01);

    always_comb begin
        w_misal = 1'b0;
        if (w_is_half) begin
            w_misal = ex_mem_alu_result[0];
        end else if (!w_is_byte) begin
            w_misal = (ex_mem_alu_result[1:0] != 2'b00);
        end
    end

    always_comb begin
        w_req_be    = 4'b1111;
        w_req_wdata = ex_mem_dm_w_data;
        if (w_is_byte) begin
            w_req_be    = 4'b0001 << ex_mem_alu_result[1:0];
            w_req_wdata = {4{ex_mem_dm_w_data[7:0]}};
        end else if (w_is_half) begin
            w_req_be    = ex_mem_alu_result[1] ? 4'b1100 : 4'b0011;
            w_req_wdata = {2{ex_mem_dm_w_data[15:0]}};
        end
    end

    always_comb begin
        w_lane_b = mem.mem_rdata[7:0];
        unique case (r_off)
            2'd0:    w_lane_b = mem.mem_rdata[7:0];
            2'd1:    w_lane_b = mem.mem_rdata[15:8];
            2'd2:    w_lane_b = mem.mem_rdata[23:16];
            default: w_lane_b = mem.mem_rdata[31:24];
        endcase
        w_lane_h = r_off[1] ? mem.mem_rdata[31:16]
                            : mem.mem_rdata[15:0];
    end

    always_comb begin
        w_ld_data = mem.mem_rdata;
        if (r_size == 2'b00) begin
            w_ld_data = {{24{r_sext & w_lane_b[7]}}, w_lane_b};
        end else if (r_size == 2'b01) begin
            w_ld_data = {{16{r_sext & w_lane_h[15]}}, w_lane_h};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_r_data    <= 32'd0;
            r_r_valid   <= 1'b0;
            r_fault     <= 1'b0;
            r_timeout   <= 1'b0;
            r_load      <= 1'b0;
            r_size      <= 2'd0;
            r_off       <= 2'd0;
            r_sext      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_be    <= w_mem_be;
            r_mem_wdata <= w_mem_wdata;
            r_r_data    <= w_r_data;
            r_r_valid   <= w_r_valid;
            r_fault     <= w_fault;
            r_timeout   <= w_timeout;
            r_load      <= w_load;
            r_size      <= w_size;
            r_off       <= w_off;
            r_sext      <= w_sext;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_be    = r_mem_be;
        w_mem_wdata = r_mem_wdata;
        w_r_data    = r_r_data;
        w_r_valid   = 1'b0;
        w_fault     = 1'b0;
        w_timeout   = 1'b0;
        w_load      = r_load;
        w_size      = r_size;
        w_off       = r_off;
        w_sext      = r_sext;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    if (w_conflict || w_misal) begin
                        w_state = S_DONE;
                        w_fault = 1'b1;
                    end else begin
                        w_state     = S_ACCESS;
                        w_cnt       = 8'd0;
                        w_mem_req   = 1'b1;
                        w_mem_we    = ex_mem_dm_w;
                        w_mem_addr  = {ex_mem_alu_result[31:2], 2'b00};
                        w_mem_be    = w_req_be;
                        w_mem_wdata = w_req_wdata;
                        w_load      = ex_mem_dm_r;
                        w_size      = ex_mem_dm_size;
                        w_off       = ex_mem_alu_result[1:0];
                        w_sext      = ex_mem_dm_sext;
                    end
                end
            end
            S_ACCESS: begin
                // An ack in the final counted cycle still completes normally
                if (mem.mem_ack) begin
                    w_state   = S_DONE;
                    w_mem_req = 1'b0;
                    if (r_load) begin
                        w_r_data  = w_ld_data;
                        w_r_valid = 1'b1;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_state   = S_DONE;
                    w_mem_req = 1'b0;
                    w_timeout = 1'b1;
                    w_r_data  = 32'd0;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign dm_stall = ((r_state == S_IDLE) && w_any_req)
                    || (r_state == S_ACCESS);

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_be    = r_mem_be;
    assign mem.mem_wdata = r_mem_wdata;

    assign dm_r_data  = r_r_data;
    assign dm_r_valid = r_r_valid;
    assign dm_fault   = r_fault;
    assign dm_timeout = r_timeout;

endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max ACCESS cycles awaiting mem_ack (8-bit counter).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ex_mem_dm_r  in  1  load request from MEM-stage pipeline register.
REQ-005 ex_mem_dm_w  in  1  store request from MEM-stage pipeline register.
REQ-006 ex_mem_alu_result  in  32  byte address.
REQ-007 ex_mem_dm_w_data  in  32  store data, right-justified.
REQ-008 ex_mem_dm_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 ex_mem_dm_sext  in  1  1 = sign-extend loaded byte/half, 0 = zero-extend.
REQ-010 mem_req  out  1  registered bus request.
REQ-011 mem_we  out  1  registered; 1 = write.
REQ-012 mem_addr  out  32  registered word address, bits [1:0] = 0.
REQ-013 mem_be  out  4  registered byte enables, little-endian lanes.
REQ-014 mem_wdata  out  32  registered lane-replicated store data.
REQ-015 mem_ack  in  1  bus completion, one-cycle pulse.
REQ-016 mem_rdata  in  32  read word, valid with mem_ack.
REQ-017 dm_stall  out  1  combinational; 1 = pipeline must hold EX/MEM contents.
REQ-018 dm_r_data  out  32  registered aligned/extended load result.
REQ-019 dm_r_valid  out  1  registered one-cycle pulse, load completed.
REQ-020 dm_fault  out  1  registered one-cycle pulse, misaligned or conflicting request.
REQ-021 dm_timeout  out  1  registered one-cycle pulse, bus timeout.

Function
REQ-022 FSM states IDLE, ACCESS, DONE; DONE SHALL always go to IDLE next cycle.
REQ-023 IDLE with exactly one of dm_r/dm_w and aligned address -> ACCESS; mem_req=1, mem_we=dm_w, address/enables/data registered same edge.
REQ-024 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or dm_r&dm_w both set -> DONE with dm_fault=1, no bus request.
REQ-025 dm_stall = (IDLE and (dm_r or dm_w)) or ACCESS; SHALL be 0 in DONE so pipeline advances exactly once.
REQ-026 mem_req, mem_we, mem_addr, mem_be, mem_wdata SHALL stay constant throughout ACCESS.
REQ-027 Byte: mem_be = 0001 << addr[1:0], mem_wdata = 4 copies of data[7:0]; half: mem_be = addr[1]?1100:0011, mem_wdata = 2 copies of data[15:0]; word: 1111, data unchanged.
REQ-028 ACCESS with mem_ack=1 -> DONE, mem_req=0 same edge; load extracts addressed lane of mem_rdata, extends per ex_mem_dm_sext, sets dm_r_valid=1.
REQ-029 Store completion SHALL leave dm_r_data unchanged with dm_r_valid=0.
REQ-030 Counter clears on IDLE->ACCESS, increments per ACCESS cycle without ack; ACCESS cycle where count==TIMEOUT-1 and no ack -> DONE, dm_timeout=1, dm_r_data=0, mem_req=0.
REQ-031 Ack arriving in the timeout cycle SHALL win (normal completion, no timeout).
REQ-032 mem_ack outside ACCESS SHALL be ignored.
REQ-033 Minimum latency: request cycle + one ACCESS cycle with ack = 2 stall cycles, result in DONE cycle.
REQ-034 Back-to-back: next request SHALL be accepted in IDLE cycle immediately after DONE.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE, counter 0, and all outputs 0 (mem_addr, mem_be, mem_wdata, dm_r_data included), from any state incl. mid-ACCESS; dm_stall then 0 unless a request is present.
REQ-036 A mem_ack coincident with reset SHALL be ignored; no pulse outputs afterward.

Verification
REQ-037 Word load addr 0x100, ack after 3 ACCESS cycles, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, 4 stall cycles, dm_r_data 0xDEADBEEF, dm_r_valid one cycle.
REQ-038 Byte load addr 0x103, sext=1, rdata 0x80FF0011 -> be 1000, dm_r_data 0xFFFFFF80; sext=0 -> 0x00000080.
REQ-039 Half store addr 0x202, data 0x0000ABCD -> mem_addr 0x200, be 1100, mem_wdata 0xABCDABCD, mem_we=1, dm_r_valid=0.
REQ-040 Word load addr 0x101 -> no mem_req, 1 stall cycle, dm_fault pulse; dm_r and dm_w both set -> same.
REQ-041 TIMEOUT=4, no ack -> dm_timeout pulse after 4 ACCESS cycles, dm_r_data 0, mem_req low; repeat with ack in 4th cycle -> normal completion.
REQ-042 reset asserted in 2nd ACCESS cycle with ack -> next cycle IDLE, mem_req 0, no dm_r_valid/dm_timeout pulse.
